switch_debouncer: RTL and testbench

//   Input stage between the board slide switches and the LED / 7-segment display stage.

---
 rtl/switch_pkg.sv | 9 +
 rtl/debounce_channel.sv | 43 ++++
 rtl/switch_debouncer.sv | 30 +++
 tb/tb_switch_debouncer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared switch-bank sizing and debounce timing helpers.
package switch_pkg;
  localparam int DEFAULT_N_SW = 6;
  localparam int DEFAULT_CLK_HZ = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_MS = 10;
  function automatic int calc_stable_cyc(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one switch line, synchronised, debounced, with edge pulses.
module debounce_channel #(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYC - 1);
  logic meta_q, sync_q, stable_q, stable_d, rise_q, rise_d, fall_q, fall_d, commit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    commit = (sync_q != stable_q) && (cnt_q == LAST);
    cnt_d = (sync_q == stable_q || commit) ? '0 : cnt_q + 1'b1;
    stable_d = commit ? sync_q : stable_q;
    rise_d = commit & sync_q;
    fall_d = commit & ~sync_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q <= '0;
      stable_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      cnt_q <= cnt_d;
      stable_q <= stable_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign stable = stable_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: bank of independent debounced switch channels with change flag.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int N_SW = DEFAULT_N_SW,
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [0:N_SW-1] sw_raw,
  output logic [0:N_SW-1] sw_stable,
  output logic [0:N_SW-1] sw_rise,
  output logic [0:N_SW-1] sw_fall,
  output logic            any_change
);
  localparam int STABLE_CYC = calc_stable_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    debounce_channel #(.STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)) u_ch (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i])
    );
  end
  assign any_change = |(sw_rise | sw_fall);
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed stimulus with a queued scoreboard checked on any_change.
module tb_switch_debouncer;
  logic clock = 1'b0;
  logic reset_n;
  logic [0:5] sw_raw, sw_stable, sw_rise, sw_fall;
  logic any_change;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    int cyc;
    logic [0:5] st, ri, fa;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  switch_debouncer #(.N_SW(6), .CLK_HZ(1000), .DEBOUNCE_MS(4)) dut (
    .clock(clock), .reset_n(reset_n), .sw_raw(sw_raw), .sw_stable(sw_stable),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .any_change(any_change)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [0:5] v);
    @(negedge clock);
    sw_raw = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Expected event lands 2 sync + 4 qualify cycles after the current negedge.
  task automatic push(input logic [0:5] st, input logic [0:5] ri, input logic [0:5] fa);
    exp_t e;
    e.cyc = cyc + 6;
    e.st = st;
    e.ri = ri;
    e.fa = fa;
    sbq.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stable"}, 32'(sw_stable), 0);
    chk({tag, "_rise"}, 32'(sw_rise), 0);
    chk({tag, "_fall"}, 32'(sw_fall), 0);
    chk({tag, "_any"}, 32'(any_change), 0);
  endtask

  always @(negedge clock) begin
    if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
      chk("event_missing", cyc, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    if (any_change) begin
      if (sbq.size() == 0) chk("unexpected_any_change", 32'(any_change), 0);
      else begin
        mon_e = sbq.pop_front();
        chk("event_cycle", cyc, mon_e.cyc);
        chk("event_stable", 32'(sw_stable), 32'(mon_e.st));
        chk("event_rise", 32'(sw_rise), 32'(mon_e.ri));
        chk("event_fall", 32'(sw_fall), 32'(mon_e.fa));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    sw_raw = 6'b111111;
    idle(3);
    #1 chk_zero("reset_hold");
    @(negedge clock);
    reset_n = 1'b1;
    push(6'b111111, 6'b111111, 6'b000000);
    idle(10);
    drive(6'b000000);
    push(6'b000000, 6'b000000, 6'b111111);
    idle(10);
    drive(6'b100000);
    push(6'b100000, 6'b100000, 6'b000000);
    idle(10);
    drive(6'b101000); idle(2);
    drive(6'b100000); idle(2);
    drive(6'b101000); idle(2);
    drive(6'b100000); idle(2);
    drive(6'b101000);
    push(6'b101000, 6'b001000, 6'b000000);
    idle(10);
    drive(6'b101001); idle(2);
    drive(6'b101000);
    idle(10);
    chk("glitch_stable", 32'(sw_stable), 32'(6'b101000));
    drive(6'b111000);
    idle(3);
    @(negedge clock);
    reset_n = 1'b0;
    #1 chk_zero("reset_mid");
    idle(2);
    reset_n = 1'b1;
    push(6'b111000, 6'b111000, 6'b000000);
    idle(10);
    drive(6'b101010);
    push(6'b101010, 6'b000010, 6'b010000);
    idle(10);
    drive(6'b010101);
    push(6'b010101, 6'b010101, 6'b101010);
    idle(10);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
